// File: rtl/frame_reader.sv
// -----------------------------------------------------------------------------
// frame_reader
//
// Streams one captured frame out of the frame-buffer BRAM read port as a
// valid/ready pixel stream tagged with start-of-frame, end-of-line and
// end-of-frame markers. Read addresses are linear (0 .. N-1). The BRAM's
// one-cycle read latency is absorbed by a 4-entry output FIFO. Reads are only
// issued while FIFO occupancy plus in-flight reads is below 4, so a pixel can
// never be dropped or duplicated under downstream backpressure.
//
// Parameters
//   WIDTH   pixel width in bits (equal to the BRAM data width)
//   H_PIX   pixels per line
//   V_PIX   lines per frame
//
// Ports
//   i_clk        clock (also the BRAM read clock)
//   i_rst        synchronous active-high reset
//   i_start      frame readout request, ignored while o_busy=1
//   o_busy       readout in progress (through the o_done cycle)
//   o_done       one-cycle pulse after the last pixel handshake
//   o_rd         BRAM read enable
//   o_rd_addr    BRAM read address
//   i_rd_data    BRAM read data, valid the cycle after o_rd
//   o_pix_valid  pixel and markers valid
//   i_pix_ready  downstream accepts the pixel
//   o_pix_data   pixel value
//   o_sof        pixel 0 of the frame
//   o_eol        last pixel of a line
//   o_eof        last pixel of the frame
// -----------------------------------------------------------------------------
module frame_reader #(
  parameter int WIDTH = 12,
  parameter int H_PIX = 160,
  parameter int V_PIX = 120,
  localparam int N    = H_PIX * V_PIX,
  localparam int AW   = $clog2(N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_rd,
  output logic [AW-1:0]    o_rd_addr,
  input  logic [WIDTH-1:0] i_rd_data,
  output logic             o_pix_valid,
  input  logic             i_pix_ready,
  output logic [WIDTH-1:0] o_pix_data,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof
);

  localparam int XW    = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW    = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int EW    = WIDTH + 3;
  localparam int DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [AW-1:0] addr_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  logic          addr_last;
  logic          x_last;
  logic          y_last;
  logic          start_go;
  logic          rd_issue;
  logic          drain_clear;

  logic          vld_p1;
  logic          sof_p1;
  logic          eol_p1;
  logic          eof_p1;

  logic [EW-1:0] fifo_mem [DEPTH];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [2:0]    fifo_cnt;
  logic [2:0]    credit;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  assign addr_last   = (addr_q == AW'(N - 1));
  assign x_last      = (x_q == XW'(H_PIX - 1));
  assign y_last      = (y_q == YW'(V_PIX - 1));
  assign start_go    = (state_q == S_IDLE) && i_start;

  // Credit counts FIFO entries plus the read still in flight from the BRAM.
  // A pop in this cycle is deliberately not counted.
  assign credit      = fifo_cnt + {2'b00, vld_p1};
  assign rd_issue    = (state_q == S_READ) && (credit < 3'(DEPTH));
  assign drain_clear = (fifo_cnt == 3'd0) && !vld_p1;

  assign push        = vld_p1;
  assign pop         = o_pix_valid && i_pix_ready;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (rd_issue && addr_last) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_clear) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM: outputs
  always_comb begin
    o_busy = (state_q != S_IDLE);
    o_rd   = rd_issue;
    o_done = (state_q == S_DRAIN) && drain_clear;
  end

  // ---------------------------------------------------------------------------
  // Stage p0: read issue (address and x/y position counters)
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst || start_go) begin
      addr_q <= '0;
      x_q    <= '0;
      y_q    <= '0;
    end else if (rd_issue) begin
      // Wrap rather than step past N-1 so the address stays in range.
      addr_q <= addr_last ? '0 : addr_q + AW'(1);
      if (x_last) begin
        x_q <= '0;
        y_q <= y_last ? '0 : y_q + YW'(1);
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign o_rd_addr = addr_q;

  // ---------------------------------------------------------------------------
  // Stage p1: BRAM data returns, markers travel alongside it
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= rd_issue;
    end
  end

  always_ff @(posedge i_clk) begin
    if (rd_issue) begin
      sof_p1 <= (addr_q == '0);
      eol_p1 <= x_last;
      eof_p1 <= x_last && y_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p2: output FIFO, head drives the pixel interface
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst || start_go) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {eof_p1, eol_p1, sof_p1, i_rd_data};
    end
  end

  assign head        = fifo_mem[rd_ptr];
  assign o_pix_valid = (fifo_cnt != 3'd0);

  // Storage is not reset, so the visible fields are qualified by valid.
  assign o_pix_data  = o_pix_valid ? head[WIDTH-1:0] : '0;
  assign o_sof       = o_pix_valid && head[WIDTH];
  assign o_eol       = o_pix_valid && head[WIDTH+1];
  assign o_eof       = o_pix_valid && head[WIDTH+2];

endmodule

// File: tb/tb_frame_reader.sv
module tb_frame_reader;

  localparam int WIDTH = 12;
  localparam int H     = 160;
  localparam int V     = 120;
  localparam int N     = H * V;
  localparam int AW    = $clog2(N);

  logic             i_clk;
  logic             i_rst;
  logic             i_start;
  logic             o_busy;
  logic             o_done;
  logic             o_rd;
  logic [AW-1:0]    o_rd_addr;
  logic [WIDTH-1:0] i_rd_data;
  logic             o_pix_valid;
  logic             i_pix_ready;
  logic [WIDTH-1:0] o_pix_data;
  logic             o_sof;
  logic             o_eol;
  logic             o_eof;

  frame_reader #(
    .WIDTH(WIDTH),
    .H_PIX(H),
    .V_PIX(V)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_rd       (o_rd),
    .o_rd_addr  (o_rd_addr),
    .i_rd_data  (i_rd_data),
    .o_pix_valid(o_pix_valid),
    .i_pix_ready(i_pix_ready),
    .o_pix_data (o_pix_data),
    .o_sof      (o_sof),
    .o_eol      (o_eol),
    .o_eof      (o_eof)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // BRAM model: one-cycle read latency, returns the low 12 address bits.
  always @(posedge i_clk) begin
    if (o_rd) i_rd_data <= o_rd_addr[11:0];
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Scoreboard and monitor state.
  logic [WIDTH+2:0] sb_q[$];
  int  issued = 0, popped = 0, done_cnt = 0, done_cyc = 0;
  int  issued_base = 0, popped_base = 0, done_base = 0, t0 = 0;
  bit  mon_en = 0, chk_timing = 0;
  int  rdy_mode = 1;

  function automatic logic [WIDTH+2:0] mk_word(input int k);
    logic [11:0] d;
    d = k[11:0];
    return {(k == N - 1), ((k % H) == H - 1), (k == 0), d};
  endfunction

  task automatic arm();
    sb_q.delete();
    for (int k = 0; k < N; k++) sb_q.push_back(mk_word(k));
    issued_base = issued;
    popped_base = popped;
    done_base   = done_cnt;
    t0          = cyc;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while ((done_cnt - done_base) == 0 && n < max) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    if ((done_cnt - done_base) == 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_idle(input string pfx);
    chk({pfx, "_ctl"}, {o_busy, o_done, o_rd, o_pix_valid, o_sof, o_eol, o_eof}, 0);
    chk({pfx, "_addr"}, 32'(o_rd_addr), 0);
    chk({pfx, "_data"}, 32'(o_pix_data), 0);
  endtask

  // Random ready driver, active only in mode 2.
  initial begin
    forever begin
      @(posedge i_clk);
      #2;
      if (rdy_mode == 2) i_pix_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: address sequence, credit bound, hold-while-stalled, scoreboard.
  initial begin
    bit               prev_stall;
    logic [WIDTH+2:0] prev_word;
    logic [WIDTH+2:0] exp_w;
    prev_stall = 0;
    prev_word  = '0;
    forever begin
      @(negedge i_clk);
      if (mon_en) begin
        if (o_rd) begin
          chk("rd_addr", 32'(o_rd_addr), 32'(issued - issued_base));
          chk("credit_lt4", 32'(((issued - issued_base) - (popped - popped_base)) < 4), 1);
          issued++;
        end
        if (prev_stall)
          chk("hold", {o_pix_valid, o_eof, o_eol, o_sof, o_pix_data}, {1'b1, prev_word});
        if (o_pix_valid && i_pix_ready) begin
          if (sb_q.size() == 0) chk("extra_pix", 1, 0);
          else begin
            exp_w = sb_q.pop_front();
            chk("pix", {o_eof, o_eol, o_sof, o_pix_data}, 32'(exp_w));
          end
          if (chk_timing) chk("pix_cyc", cyc, t0 + 3 + (popped - popped_base));
          popped++;
        end
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        prev_stall = o_pix_valid && !i_pix_ready;
        prev_word  = {o_eof, o_eol, o_sof, o_pix_data};
      end else begin
        prev_stall = 0;
      end
    end
  end

  int r_cyc;

  initial begin
    i_rst       = 1'b1;
    i_start     = 1'b0;
    i_pix_ready = 1'b1;
    rdy_mode    = 1;
    goto(3);
    @(negedge i_clk);
    check_idle("reset");
    goto(4);
    i_rst  = 1'b0;
    mon_en = 1;

    // Frame 1: ready held high, start pulses during READ and in o_done cycle.
    chk_timing = 1;
    arm();
    i_start = 1'b1;
    goto(t0 + 1);
    i_start = 1'b0;
    @(negedge i_clk);
    chk("start_lat", {o_busy, o_rd, (o_rd_addr == '0)}, 3'b111);
    goto(t0 + 100);
    i_start = 1'b1;
    goto(t0 + 101);
    i_start = 1'b0;
    goto(t0 + N + 3);
    i_start = 1'b1;
    @(negedge i_clk);
    chk("done_pulse", {o_done, o_busy}, 2'b11);
    goto(t0 + N + 4);
    chk_timing = 0;
    chk("done_cnt1", done_cnt - done_base, 1);
    chk("done_cyc1", done_cyc, t0 + N + 3);
    chk("sb_left1", sb_q.size(), 0);

    // Frame 2: started in the cycle after o_done, ready low from the start.
    i_pix_ready = 1'b0;
    rdy_mode    = 0;
    arm();
    @(negedge i_clk);
    chk("idle_after_done", {o_busy, o_rd}, 0);
    goto(t0 + 1);
    i_start = 1'b0;
    goto(t0 + 30);
    @(negedge i_clk);
    chk("stall_reads", issued - issued_base, 4);
    chk("stall_flags", {o_rd, o_pix_valid, o_sof}, 3'b011);
    goto(t0 + 31);
    i_pix_ready = 1'b1;
    rdy_mode    = 1;
    r_cyc       = cyc;
    wait_done(N + 50);
    chk("done_cyc2", done_cyc, r_cyc + N);
    chk("sb_left2", sb_q.size(), 0);

    // Frame 3: random 50% ready.
    rdy_mode = 2;
    arm();
    i_start = 1'b1;
    goto(t0 + 1);
    i_start = 1'b0;
    wait_done(50000);
    chk("sb_left3", sb_q.size(), 0);
    chk("done_cnt3", done_cnt - done_base, 1);

    // Frame 4: reset while pixel 500 is presented and reads are in flight.
    rdy_mode    = 1;
    i_pix_ready = 1'b1;
    arm();
    i_start = 1'b1;
    goto(t0 + 1);
    i_start = 1'b0;
    goto(t0 + 503);
    i_rst = 1'b1;
    goto(t0 + 504);
    i_rst = 1'b0;
    @(negedge i_clk);
    check_idle("rst_mid");

    // Restart after reset: address 0 first, pixel 0 with sof.
    goto(cyc + 1);
    arm();
    i_start = 1'b1;
    goto(t0 + 1);
    i_start = 1'b0;
    @(negedge i_clk);
    chk("rst_restart", {o_busy, o_rd, (o_rd_addr == '0)}, 3'b111);
    goto(t0 + 3);
    @(negedge i_clk);
    chk("rst_pix0", {o_pix_valid, o_sof, o_pix_data}, {1'b1, 1'b1, 12'd0});
    goto(t0 + 20);
    i_rst = 1'b1;
    goto(t0 + 21);
    i_rst  = 1'b0;
    mon_en = 0;
    @(negedge i_clk);
    check_idle("rst_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
